// File: rtl/gf180_ram_arb_pkg.sv
// gf180_ram_arb_pkg: shared encodings for the GF180 SRAM arbiter
package gf180_ram_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
  localparam logic [63:0] WEN_IDLE = '1;
endpackage

// File: rtl/gf180_ram_rr_arb.sv
// gf180_ram_rr_arb: 2-way round-robin / fixed-priority picker with one-hot grant
module gf180_ram_rr_arb
  import gf180_ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       fixed_prio,
  output logic [1:0] gnt
);
  always_comb
    gnt = &req ? ((fixed_prio || last_gnt == PORT_B) ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/gf180_ram_arbiter.sv
// gf180_ram_arbiter: two-port Wishbone arbiter/sequencer for the GF180 1K x 32 SRAM macro
module gf180_ram_arbiter
  import gf180_ram_arb_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            a_cyc_i,
  input  logic            a_stb_i,
  input  logic            a_we_i,
  input  logic [DW/8-1:0] a_sel_i,
  input  logic [31:0]     a_adr_i,
  input  logic [DW-1:0]   a_dat_i,
  output logic [DW-1:0]   a_dat_o,
  output logic            a_ack_o,
  input  logic            b_cyc_i,
  input  logic            b_stb_i,
  input  logic            b_we_i,
  input  logic [DW/8-1:0] b_sel_i,
  input  logic [31:0]     b_adr_i,
  input  logic [DW-1:0]   b_dat_i,
  output logic [DW-1:0]   b_dat_o,
  output logic            b_ack_o,
  output logic            ram_cen,
  output logic            ram_gwen,
  output logic [DW/8-1:0] ram_wen,
  output logic [AW-1:0]   ram_a,
  output logic [DW-1:0]   ram_d,
  input  logic [DW-1:0]   ram_q
);
  localparam int SW = DW / 8;
  state_t state;
  logic grant, last_gnt, pick_b, w_we, unused_adr;
  logic [1:0] req, gnt;
  logic [SW-1:0] w_sel;
  logic [AW-1:0] w_adr;
  logic [DW-1:0] w_dat;
  assign req = {b_cyc_i & b_stb_i, a_cyc_i & a_stb_i};
  gf180_ram_rr_arb u_arb (
    .req(req),
    .last_gnt(last_gnt),
    .fixed_prio(FIXED_PRIO != 0),
    .gnt(gnt)
  );
  always_comb begin
    pick_b = gnt[1];
    w_we = pick_b ? b_we_i : a_we_i;
    w_sel = pick_b ? b_sel_i : a_sel_i;
    w_adr = pick_b ? b_adr_i[AW+1:2] : a_adr_i[AW+1:2];
    w_dat = pick_b ? b_dat_i : a_dat_i;
  end
  // Decode of the upper and byte-offset address bits happens upstream.
  assign unused_adr = ^{a_adr_i[31:AW+2], a_adr_i[1:0], b_adr_i[31:AW+2], b_adr_i[1:0]};
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      grant <= PORT_A;
      last_gnt <= PORT_B;
      ram_cen <= 1'b1;
      ram_gwen <= 1'b1;
      ram_wen <= WEN_IDLE[SW-1:0];
      ram_a <= '0;
      ram_d <= '0;
    end else begin
      case (state)
        ST_IDLE: if (|gnt) begin
          state <= ST_ACCESS;
          grant <= pick_b;
          ram_cen <= 1'b0;
          ram_gwen <= ~w_we;
          ram_wen <= w_we ? ~w_sel : WEN_IDLE[SW-1:0];
          ram_a <= w_adr;
          ram_d <= w_dat;
        end
        ST_ACCESS: begin
          state <= ST_RESP;
          ram_cen <= 1'b1;
          ram_gwen <= 1'b1;
          ram_wen <= WEN_IDLE[SW-1:0];
        end
        default: begin
          state <= ST_IDLE;
          last_gnt <= grant;
        end
      endcase
    end
  end
  // Ack only while the granted master still holds its request, so an abort is silent.
  assign a_ack_o = state == ST_RESP && grant == PORT_A && req[0];
  assign b_ack_o = state == ST_RESP && grant == PORT_B && req[1];
  assign a_dat_o = ram_q;
  assign b_dat_o = ram_q;
endmodule

// File: tb/tb_gf180_ram_arbiter.sv
// tb_gf180_ram_arbiter: directed checks of round-robin and fixed-priority arbiter instances
module tb_gf180_ram_arbiter;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  logic a_cyc = 0, a_stb = 0, a_we = 0, b_cyc = 0, b_stb = 0, b_we = 0;
  logic [3:0] a_sel = 0, b_sel = 0;
  logic [31:0] a_adr = 0, a_dat = 0, b_adr = 0, b_dat = 0;
  logic [31:0] a_dat_o, b_dat_o, ram_d, q_rr, fp_a_dat, fp_b_dat, fp_d, q_fp;
  logic a_ack, b_ack, ram_cen, ram_gwen, fp_a_ack, fp_b_ack, fp_cen, fp_gwen;
  logic [3:0] ram_wen, fp_wen;
  logic [9:0] ram_a, fp_a;
  logic [31:0] mem_rr [1024];
  logic [31:0] mem_fp [1024];
  int checks = 0, errors = 0;
  logic [9:0] cap_a;
  logic cap_gwen, cap_cen;
  logic [3:0] cap_wen;

  gf180_ram_arbiter #(.AW(10), .DW(32), .FIXED_PRIO(0)) u_rr (
    .CLK(CLK), .RST(RST),
    .a_cyc_i(a_cyc), .a_stb_i(a_stb), .a_we_i(a_we), .a_sel_i(a_sel), .a_adr_i(a_adr),
    .a_dat_i(a_dat), .a_dat_o(a_dat_o), .a_ack_o(a_ack),
    .b_cyc_i(b_cyc), .b_stb_i(b_stb), .b_we_i(b_we), .b_sel_i(b_sel), .b_adr_i(b_adr),
    .b_dat_i(b_dat), .b_dat_o(b_dat_o), .b_ack_o(b_ack),
    .ram_cen(ram_cen), .ram_gwen(ram_gwen), .ram_wen(ram_wen), .ram_a(ram_a),
    .ram_d(ram_d), .ram_q(q_rr)
  );
  gf180_ram_arbiter #(.AW(10), .DW(32), .FIXED_PRIO(1)) u_fp (
    .CLK(CLK), .RST(RST),
    .a_cyc_i(a_cyc), .a_stb_i(a_stb), .a_we_i(a_we), .a_sel_i(a_sel), .a_adr_i(a_adr),
    .a_dat_i(a_dat), .a_dat_o(fp_a_dat), .a_ack_o(fp_a_ack),
    .b_cyc_i(b_cyc), .b_stb_i(b_stb), .b_we_i(b_we), .b_sel_i(b_sel), .b_adr_i(b_adr),
    .b_dat_i(b_dat), .b_dat_o(fp_b_dat), .b_ack_o(fp_b_ack),
    .ram_cen(fp_cen), .ram_gwen(fp_gwen), .ram_wen(fp_wen), .ram_a(fp_a),
    .ram_d(fp_d), .ram_q(q_fp)
  );

  // Behavioural macro models: byte-masked write, registered read.
  always @(posedge CLK)
    if (!ram_cen) begin
      for (int i = 0; i < 4; i++)
        if (!ram_gwen && !ram_wen[i]) mem_rr[ram_a][8*i +: 8] <= ram_d[8*i +: 8];
      q_rr <= mem_rr[ram_a];
    end
  always @(posedge CLK)
    if (!fp_cen) begin
      for (int j = 0; j < 4; j++)
        if (!fp_gwen && !fp_wen[j]) mem_fp[fp_a][8*j +: 8] <= fp_d[8*j +: 8];
      q_fp <= mem_fp[fp_a];
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic p, input logic we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] dat);
    if (!p) begin
      a_cyc = 1; a_stb = 1; a_we = we; a_sel = sel; a_adr = adr; a_dat = dat;
    end else begin
      b_cyc = 1; b_stb = 1; b_we = we; b_sel = sel; b_adr = adr; b_dat = dat;
    end
  endtask

  task automatic release_port(input logic p);
    if (!p) begin a_cyc = 0; a_stb = 0; end
    else begin b_cyc = 0; b_stb = 0; end
  endtask

  // Single access on the round-robin instance; must be called just after a rising edge with both idle.
  task automatic xfer(input logic p, input logic we, input logic [3:0] sel, input logic [31:0] adr,
                      input logic [31:0] dat, input string tag, output logic [31:0] rd);
    int lat;
    logic got;
    lat = 0; got = 0; rd = '0;
    drive(p, we, sel, adr, dat);
    while (!got && lat < 20) begin
      @(negedge CLK);
      lat++;
      if (!ram_cen) begin cap_a = ram_a; cap_gwen = ram_gwen; cap_wen = ram_wen; end
      if (p ? b_ack : a_ack) begin got = 1; rd = p ? b_dat_o : a_dat_o; cap_cen = ram_cen; end
    end
    @(posedge CLK); #1;
    release_port(p);
    chk({tag, "_lat"}, lat, 3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [15:0] seq;
    logic [1:0] first;
    logic ovl, bad, seen, got;
    int a_n, b_n, k, fa, fb, lat;
    // 1: reset then idle
    idle(2);
    RST = 0;
    chk("rst_addr_data", {22'd0, ram_a} | ram_d, 32'd0);
    repeat (20) begin
      @(negedge CLK);
      chk("idle_pins", {ram_cen, ram_gwen, ram_wen, a_ack, b_ack, fp_cen, fp_a_ack, fp_b_ack},
          {1'b1, 1'b1, 4'hF, 2'b00, 1'b1, 2'b00});
    end
    idle(1);
    // 2: port A write then read, upper address bits ignored
    xfer(0, 1, 4'hF, 32'h0000_0804, 32'hDEADBEEF, "a_wr", rd);
    chk("a_wr_addr", cap_a, 10'h201);
    chk("a_wr_gwen", cap_gwen, 0);
    chk("a_wr_wen", cap_wen, 4'h0);
    chk("a_wr_cen_in_resp", cap_cen, 1);
    xfer(0, 0, 4'hF, 32'h8000_0804, 0, "a_rd", rd);
    chk("a_rd_data", rd, 32'hDEADBEEF);
    chk("a_rd_gwen", cap_gwen, 1);
    chk("a_rd_wen", cap_wen, 4'hF);
    xfer(0, 1, 4'hF, 32'h0000_0FFC, 32'h5A5AA5A5, "top_wr", rd);
    chk("top_addr", cap_a, 10'h3FF);
    xfer(0, 0, 4'hF, 32'h0000_0FFC, 0, "top_rd", rd);
    chk("top_data", rd, 32'h5A5AA5A5);
    // 3: byte write and empty-select write on port B
    xfer(1, 1, 4'hF, 32'h10, 32'h11223344, "b_wr", rd);
    xfer(1, 1, 4'b0100, 32'h10, 32'h00AA0000, "b_byte", rd);
    chk("b_byte_wen", cap_wen, 4'b1011);
    xfer(1, 0, 4'hF, 32'h10, 0, "b_rd", rd);
    chk("b_byte_data", rd, 32'h11AA3344);
    xfer(1, 1, 4'h0, 32'h10, 32'hFFFFFFFF, "b_sel0", rd);
    chk("b_sel0_wen", cap_wen, 4'hF);
    chk("b_sel0_gwen", cap_gwen, 0);
    xfer(1, 0, 4'hF, 32'h10, 0, "b_rd2", rd);
    chk("b_sel0_data", rd, 32'h11AA3344);
    // 4: round-robin contention, last grant was B so A goes first
    a_n = 0; b_n = 0; k = 0; seq = '0; ovl = 0; bad = 0;
    drive(0, 0, 4'hF, 32'h804, 0);
    drive(1, 0, 4'hF, 32'h10, 0);
    for (int c = 0; c < 60 && (a_n < 4 || b_n < 4); c++) begin
      @(negedge CLK);
      if (a_ack && b_ack) ovl = 1;
      if (a_ack) begin a_n++; if (k < 16) seq[k] = 0; k++; if (a_dat_o !== 32'hDEADBEEF) bad = 1; end
      if (b_ack) begin b_n++; if (k < 16) seq[k] = 1; k++; if (b_dat_o !== 32'h11AA3344) bad = 1; end
      @(posedge CLK); #1;
      if (a_n == 4) release_port(0);
      if (b_n == 4) release_port(1);
    end
    release_port(0);
    release_port(1);
    chk("rr_a_acks", a_n, 4);
    chk("rr_b_acks", b_n, 4);
    chk("rr_total", k, 8);
    chk("rr_order", seq, 16'b0000_0000_1010_1010);
    chk("rr_overlap", ovl, 0);
    chk("rr_data", bad, 0);
    idle(4);
    // 5: fixed priority, B stalls until A lets go
    fa = 0; fb = 0;
    drive(0, 0, 4'hF, 32'h804, 0);
    drive(1, 0, 4'hF, 32'h10, 0);
    for (int c = 0; c < 40 && fa < 3; c++) begin
      @(negedge CLK);
      if (fp_a_ack) fa++;
      if (fp_b_ack) fb++;
      @(posedge CLK); #1;
      if (fa == 3) release_port(0);
    end
    release_port(0);
    chk("fp_a_count", fa, 3);
    chk("fp_b_waits", fb, 0);
    lat = 0; got = 0; rd = '0;
    while (!got && lat < 20) begin
      @(negedge CLK);
      lat++;
      if (fp_b_ack) begin got = 1; rd = fp_b_dat; end
    end
    @(posedge CLK); #1;
    release_port(1);
    chk("fp_b_lat", lat, 3);
    chk("fp_b_data", rd, 32'h11AA3344);
    idle(4);
    // 6a: A aborts its write during ACCESS; the write still lands
    drive(0, 1, 4'hF, 32'h20, 32'hCAFEF00D);
    @(posedge CLK); #1;
    release_port(0);
    seen = 0;
    repeat (4) begin @(negedge CLK); if (a_ack) seen = 1; end
    chk("abort_no_ack", seen, 0);
    idle(1);
    xfer(1, 0, 4'hF, 32'h20, 0, "abort_rb", rd);
    chk("abort_data", rd, 32'hCAFEF00D);
    // 6b: reset during ACCESS with the request still held
    drive(0, 1, 4'hF, 32'h24, 32'h12345678);
    @(posedge CLK); #1;
    RST = 1;
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_mid_pins", {ram_cen, ram_gwen, ram_wen, a_ack, b_ack}, {1'b1, 1'b1, 4'hF, 2'b00});
    @(posedge CLK); #1;
    RST = 0;
    release_port(0);
    seen = 0;
    repeat (4) begin @(negedge CLK); if (a_ack || b_ack) seen = 1; end
    chk("rst_mid_no_ack", seen, 0);
    idle(1);
    // pointer after reset favours A
    first = 2'b00;
    drive(0, 0, 4'hF, 32'h804, 0);
    drive(1, 0, 4'hF, 32'h10, 0);
    for (int c = 0; c < 20 && first == 2'b00; c++) begin
      @(negedge CLK);
      first = {b_ack, a_ack};
    end
    @(posedge CLK); #1;
    release_port(0);
    release_port(1);
    chk("rst_ptr_first", first, 2'b01);
    idle(6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
